param_stack: RTL and testbench

//   Parametrised LIFO stack with configurable data width and depth.

---
 rtl/param_stack_if.sv | 55 +++++
 rtl/param_stack.sv | 140 ++++++++++++++
 tb/tb_param_stack.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/param_stack_if.sv
// ----------------------------------------------------------------------------
// param_stack_if
//   Bundles the request and status signals of param_stack.
//   The master side (the user of the stack) drives the requests and reads the
//   status. The slave side (the stack itself) does the reverse.
//
//   Requests (master -> slave)
//     i_data_in      WIDTH   word to push
//     i_push         1       push request
//     i_pop          1       pop request
//     i_clr_err      1       clear the sticky overflow/underflow flags
//   Status (slave -> master)
//     o_data_out     WIDTH   registered popped word
//     o_valid_out    1       one-cycle strobe, o_data_out refreshed by a pop
//     o_top          WIDTH   combinational peek of the top entry, 0 when empty
//     o_count        CNT_W   number of stored entries
//     o_full         1       count == DEPTH
//     o_empty        1       count == 0
//     o_almost_full  1       count >= AF_THRESH
//     o_overflow     1       sticky, a push was refused on a full stack
//     o_underflow    1       sticky, a pop was refused on an empty stack
// ----------------------------------------------------------------------------
interface param_stack_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] i_data_in;
    logic             i_push;
    logic             i_pop;
    logic             i_clr_err;

    logic [WIDTH-1:0] o_data_out;
    logic             o_valid_out;
    logic [WIDTH-1:0] o_top;
    logic [CNT_W-1:0] o_count;
    logic             o_full;
    logic             o_empty;
    logic             o_almost_full;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_data_in, i_push, i_pop, i_clr_err,
        input  o_data_out, o_valid_out, o_top, o_count, o_full, o_empty,
               o_almost_full, o_overflow, o_underflow
    );

    modport slave (
        input  i_data_in, i_push, i_pop, i_clr_err,
        output o_data_out, o_valid_out, o_top, o_count, o_full, o_empty,
               o_almost_full, o_overflow, o_underflow
    );
endinterface

// File: rtl/param_stack.sv
// ----------------------------------------------------------------------------
// param_stack
//   Single-clock parametrised LIFO with occupancy count, top-of-stack peek,
//   almost-full flag, sticky overflow/underflow flags and a pop-valid strobe.
//
//   Ports
//     clk    in   rising-edge clock
//     rstN   in   synchronous, active-high reset (despite the name)
//     bus    slave modport of param_stack_if (requests in, status out)
//
//   Parameters
//     WIDTH      data word width (>= 1)
//     DEPTH      number of entries (>= 2)
//     AF_THRESH  almost-full threshold on count (1..DEPTH)
// ----------------------------------------------------------------------------
module param_stack #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    param_stack_if.slave         bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage and registered state
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_overflow;
    logic             r_underflow;

    // Decoded request and status terms
    logic             w_full;
    logic             w_empty;
    logic             w_almost_full;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_both;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [WIDTH-1:0] w_top_data;

    // Occupancy flags derived straight from the count
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_almost_full = (32'(r_count) >= AF_THRESH);

    assign w_push_only = bus.i_push & ~bus.i_pop;
    assign w_pop_only  = bus.i_pop  & ~bus.i_push;
    assign w_both      = bus.i_push &  bus.i_pop;

    // Index held at 0 when empty so the read never addresses past the array
    assign w_top_idx  = w_empty ? '0 : AW'(r_count - CNT_W'(1));
    assign w_top_data = r_mem[w_top_idx];

    // Push+pop on a non-empty stack overwrites the top entry in place;
    // on an empty stack it degenerates to a plain push into slot 0.
    assign w_wr_en  = ~rstN & ((w_push_only & ~w_full) | w_both);
    assign w_wr_idx = (w_both & ~w_empty) ? w_top_idx : AW'(r_count);

    assign w_rd_en   = bus.i_pop & ~w_empty;
    assign w_inc     = (w_push_only & ~w_full) | (w_both & w_empty);
    assign w_dec     = w_pop_only & ~w_empty;
    assign w_ovf_set = w_push_only & w_full;
    assign w_udf_set = bus.i_pop & w_empty;

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.i_data_in;
        end
    end

    // Count, popped word and strobe
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_en;
            if (w_rd_en) begin
                r_data_out <= w_top_data;
            end
            if (w_inc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_dec) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky error flags; a fresh error outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.o_data_out    = r_data_out;
    assign bus.o_valid_out   = r_valid_out;
    assign bus.o_top         = w_empty ? '0 : w_top_data;
    assign bus.o_count       = r_count;
    assign bus.o_full        = w_full;
    assign bus.o_empty       = w_empty;
    assign bus.o_almost_full = w_almost_full;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_underflow   = r_underflow;

    // Count must stay within 0..DEPTH
    a_count_range: assert property (@(posedge clk) disable iff (rstN)
        r_count <= CNT_W'(DEPTH));

    // Empty and full are mutually exclusive for DEPTH >= 1
    a_full_empty: assert property (@(posedge clk) disable iff (rstN)
        !(w_full && w_empty));

endmodule

// File: tb/tb_param_stack.sv
// ----------------------------------------------------------------------------
// tb_param_stack
//   Directed bench for param_stack (WIDTH=4, DEPTH=8, AF_THRESH=7).
//   A queue-based model tracks the expected contents and flags; a compare
//   process checks every DUT output against it on each falling edge, and the
//   stimulus sequence adds hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_param_stack;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = DEPTH - 1;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    always #5 clk = ~clk;

    param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: a queue whose back is the top of stack
    int         q[$];
    logic [3:0] m_dout  = '0;
    bit         m_valid = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_udf   = 1'b0;

    always @(posedge clk) begin
        if (rstN) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (bus.i_clr_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (bus.i_push && bus.i_pop) begin
                if (q.size() > 0) begin
                    m_dout = 4'(q[q.size()-1]);
                    q[q.size()-1] = int'(bus.i_data_in);
                    m_valid = 1'b1;
                end else begin
                    q.push_back(int'(bus.i_data_in));
                    m_udf = 1'b1;
                end
            end else if (bus.i_push) begin
                if (q.size() < DEPTH) q.push_back(int'(bus.i_data_in));
                else m_ovf = 1'b1;
            end else if (bus.i_pop) begin
                if (q.size() > 0) begin
                    m_dout  = 4'(q.pop_back());
                    m_valid = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            int tp;
            sz = q.size();
            tp = (sz > 0) ? q[sz-1] : 0;
            chk("m_count",    32'(bus.o_count),       32'(sz));
            chk("m_top",      32'(bus.o_top),         32'(tp));
            chk("m_full",     32'(bus.o_full),        32'(sz == DEPTH));
            chk("m_empty",    32'(bus.o_empty),       32'(sz == 0));
            chk("m_afull",    32'(bus.o_almost_full), 32'(sz >= AF));
            chk("m_dout",     32'(bus.o_data_out),    32'(m_dout));
            chk("m_valid",    32'(bus.o_valid_out),   32'(m_valid));
            chk("m_overflow", 32'(bus.o_overflow),    32'(m_ovf));
            chk("m_underflow",32'(bus.o_underflow),   32'(m_udf));
        end
    end

    // Apply one cycle of requests; returns 1 time unit after the edge
    task automatic step(input bit ps, input bit pp, input logic [3:0] d,
                        input bit clr, input bit rst);
        bus.i_push    = ps;
        bus.i_pop     = pp;
        bus.i_data_in = d;
        bus.i_clr_err = clr;
        rstN          = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_push = 1'b0; bus.i_pop = 1'b0; bus.i_data_in = '0; bus.i_clr_err = 1'b0;

        // Reset
        step(0, 0, 4'h0, 0, 1);
        chk_en = 1'b1;
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_empty", 32'(bus.o_empty), 32'd1);
        chk("rst_top",   32'(bus.o_top),   32'd0);

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 4'(i), 0, 0);
            chk("fill_afull", 32'(bus.o_almost_full), 32'(i >= 7));
        end
        chk("fill_full",  32'(bus.o_full),  32'd1);
        chk("fill_top",   32'(bus.o_top),   32'd8);
        chk("fill_count", 32'(bus.o_count), 32'd8);

        // Overflow then clear
        step(1, 0, 4'hF, 0, 0);
        chk("ovf_count", 32'(bus.o_count),    32'd8);
        chk("ovf_top",   32'(bus.o_top),      32'd8);
        chk("ovf_flag",  32'(bus.o_overflow), 32'd1);
        step(0, 0, 4'h0, 1, 0);
        chk("ovf_clr",   32'(bus.o_overflow), 32'd0);

        // Push+pop while full replaces the top
        step(1, 1, 4'hA, 0, 0);
        chk("fpp_dout",  32'(bus.o_data_out),  32'd8);
        chk("fpp_valid", 32'(bus.o_valid_out), 32'd1);
        chk("fpp_count", 32'(bus.o_count),     32'd8);
        chk("fpp_top",   32'(bus.o_top),       32'hA);
        chk("fpp_ovf",   32'(bus.o_overflow),  32'd0);

        // Drain: A,7,6,...,1
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'h0, 0, 0);
            chk("drain_dout",  32'(bus.o_data_out),  (i == 0) ? 32'hA : 32'(8 - i));
            chk("drain_valid", 32'(bus.o_valid_out), 32'd1);
        end
        chk("drain_empty", 32'(bus.o_empty), 32'd1);

        // Underflow; clear in the same cycle as an error keeps the flag
        step(0, 1, 4'h0, 0, 0);
        chk("udf_valid", 32'(bus.o_valid_out), 32'd0);
        chk("udf_dout",  32'(bus.o_data_out),  32'd1);
        chk("udf_flag",  32'(bus.o_underflow), 32'd1);
        step(0, 1, 4'h0, 1, 0);
        chk("udf_keep",  32'(bus.o_underflow), 32'd1);
        step(0, 0, 4'h0, 1, 0);
        chk("udf_clr",   32'(bus.o_underflow), 32'd0);

        // Simultaneous on {3,5}
        step(1, 0, 4'h3, 0, 0);
        step(1, 0, 4'h5, 0, 0);
        step(1, 1, 4'h9, 0, 0);
        chk("pp_dout",  32'(bus.o_data_out),  32'd5);
        chk("pp_valid", 32'(bus.o_valid_out), 32'd1);
        chk("pp_count", 32'(bus.o_count),     32'd2);
        chk("pp_top",   32'(bus.o_top),       32'd9);
        step(0, 0, 4'h0, 0, 0);
        chk("strobe_drop", 32'(bus.o_valid_out), 32'd0);

        // Reset mid-traffic, with an underflow pending
        step(0, 1, 4'h0, 0, 0);
        step(0, 1, 4'h0, 0, 0);
        step(0, 1, 4'h0, 0, 0);
        chk("pre_rst_udf", 32'(bus.o_underflow), 32'd1);
        step(1, 1, 4'h7, 0, 1);
        chk("mrst_count", 32'(bus.o_count),     32'd0);
        chk("mrst_empty", 32'(bus.o_empty),     32'd1);
        chk("mrst_dout",  32'(bus.o_data_out),  32'd0);
        chk("mrst_valid", 32'(bus.o_valid_out), 32'd0);
        chk("mrst_udf",   32'(bus.o_underflow), 32'd0);
        chk("mrst_ovf",   32'(bus.o_overflow),  32'd0);

        // Push+pop on empty
        step(1, 1, 4'h6, 0, 0);
        chk("epp_count", 32'(bus.o_count),     32'd1);
        chk("epp_top",   32'(bus.o_top),       32'd6);
        chk("epp_valid", 32'(bus.o_valid_out), 32'd0);
        chk("epp_udf",   32'(bus.o_underflow), 32'd1);

        // Mixed traffic, push-biased then pop-biased, checked by the model
        for (int i = 0; i < 300; i++) begin
            bit ps, pp, clr, rst;
            if (i < 150) begin
                ps = ($urandom_range(0, 3) != 0);
                pp = ($urandom_range(0, 3) == 0);
            end else begin
                ps = ($urandom_range(0, 3) == 0);
                pp = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step(ps, pp, 4'($urandom_range(0, 15)), clr, rst);
        end

        step(0, 0, 4'h0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
